mul_sequencer: RTL and testbench

RV32M multiply front-end for the PE execute stage. It accepts MUL/MULH/MULHSU/MULHU ops through a valid/ready handshake and drives the iterative signed 32×32 Booth multiplier through its start/done interface. It then applies unsigned-operand correction to the upper word and returns the selected 32-bit half through a valid/ready handshake to writeback. A one-entry product cache lets a MUL that follows a MULH* on the same operands skip the multiplier.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/mul_hi_correct.sv | 44 ++++
 rtl/mul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared execute-stage definitions: multiply op encodings, sequencer states
// and the default datapath width.
package pe_pkg;

   localparam int PE_XLEN = 32;

   // funct3[1:0] of the RV32M multiply group
   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_t;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_START = 3'd1,
      SEQ_WAIT  = 3'd2,
      SEQ_CORR  = 3'd3,
      SEQ_OUT   = 3'd4,
      SEQ_DRAIN = 3'd5
   } mul_seq_state_t;

endpackage

// File: rtl/mul_hi_correct.sv
// Turns the signed 64-bit Booth product into the 32-bit result of the
// requested RV32M op. Unsigned operands are recovered by adding the other
// operand into the upper word whenever an operand's top bit is set.
module mul_hi_correct
   import pe_pkg::*;
#(
   parameter int XLEN = PE_XLEN
) (
   input  mul_op_t           op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [2*XLEN-1:0] p,
   output logic [XLEN-1:0]   result
);

   logic [XLEN-1:0] hi_s;
   logic [XLEN-1:0] add_a_s;
   logic [XLEN-1:0] add_b_s;

   // Select the half and apply the unsigned-operand correction terms
   always_comb begin
      hi_s    = p[2*XLEN-1:XLEN];
      add_a_s = {XLEN{1'b0}};
      add_b_s = {XLEN{1'b0}};
      if (b[XLEN-1]) begin
         add_a_s = a;
      end else begin
         add_a_s = {XLEN{1'b0}};
      end
      if (a[XLEN-1]) begin
         add_b_s = b;
      end else begin
         add_b_s = {XLEN{1'b0}};
      end
      case (op)
         MUL_OP_MUL:    result = p[XLEN-1:0];
         MUL_OP_MULH:   result = hi_s;
         MUL_OP_MULHSU: result = hi_s + add_a_s;
         MUL_OP_MULHU:  result = hi_s + add_a_s + add_b_s;
         default:       result = hi_s;
      endcase
   end

endmodule

// File: rtl/mul_sequencer.sv
// RV32M multiply front-end: accepts MUL/MULH/MULHSU/MULHU, drives an
// external iterative signed multiplier through start/done, corrects the
// upper word for unsigned operands and hands the result to writeback.
// A one-entry product cache lets an op on the operands of the previous
// completed multiply skip the multiplier entirely.
module mul_sequencer
   import pe_pkg::*;
#(
   parameter int XLEN  = PE_XLEN,
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [TAG_W-1:0]  in_rd,
   input  logic              flush,
   output logic [XLEN-1:0]   mul_multiplicand,
   output logic [XLEN-1:0]   mul_multiplier,
   output logic              mul_start,
   input  logic [2*XLEN-1:0] mul_product,
   input  logic              mul_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [TAG_W-1:0]  out_rd
);

   mul_seq_state_t    state_r;
   mul_op_t           op_r;
   logic [TAG_W-1:0]  rd_r;
   logic              cache_vld_r;
   logic [XLEN-1:0]   cache_a_r;
   logic [XLEN-1:0]   cache_b_r;
   logic [2*XLEN-1:0] cache_p_r;

   logic              cache_hit_s;
   logic [XLEN-1:0]   corr_result_s;

   // Accept only in IDLE; this is the one combinational output
   assign in_ready = (state_r == SEQ_IDLE);

   // Hit when the offered operands match the last completed product
   assign cache_hit_s = cache_vld_r && (in_rs1 == cache_a_r) && (in_rs2 == cache_b_r);

   // The latched operands double as a and b; the product always comes from
   // the cache, which is written on every multiplier completion.
   mul_hi_correct #(
      .XLEN (XLEN)
   ) u_hi_correct (
      .op     (op_r),
      .a      (mul_multiplicand),
      .b      (mul_multiplier),
      .p      (cache_p_r),
      .result (corr_result_s)
   );

   // Sequencer FSM with registered multiplier and writeback outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= SEQ_IDLE;
         op_r             <= MUL_OP_MUL;
         rd_r             <= {TAG_W{1'b0}};
         cache_vld_r      <= 1'b0;
         cache_a_r        <= {XLEN{1'b0}};
         cache_b_r        <= {XLEN{1'b0}};
         cache_p_r        <= {(2*XLEN){1'b0}};
         mul_multiplicand <= {XLEN{1'b0}};
         mul_multiplier   <= {XLEN{1'b0}};
         mul_start        <= 1'b0;
         out_valid        <= 1'b0;
         out_result       <= {XLEN{1'b0}};
         out_rd           <= {TAG_W{1'b0}};
      end else begin
         mul_start <= 1'b0;
         case (state_r)
            SEQ_IDLE: begin
               if (flush) begin
                  cache_vld_r <= 1'b0;
               end else if (in_valid) begin
                  op_r             <= mul_op_t'(in_op);
                  rd_r             <= in_rd;
                  mul_multiplicand <= in_rs1;
                  mul_multiplier   <= in_rs2;
                  if (cache_hit_s) begin
                     state_r <= SEQ_CORR;
                  end else begin
                     state_r   <= SEQ_START;
                     mul_start <= 1'b1;
                  end
               end else begin
                  state_r <= SEQ_IDLE;
               end
            end
            SEQ_START: begin
               // The start pulse has already gone out; a flush must drain it
               if (flush) begin
                  cache_vld_r <= 1'b0;
                  state_r     <= SEQ_DRAIN;
               end else begin
                  state_r <= SEQ_WAIT;
               end
            end
            SEQ_WAIT: begin
               if (flush) begin
                  cache_vld_r <= 1'b0;
                  if (mul_done) begin
                     state_r <= SEQ_IDLE;
                  end else begin
                     state_r <= SEQ_DRAIN;
                  end
               end else if (mul_done) begin
                  cache_vld_r <= 1'b1;
                  cache_a_r   <= mul_multiplicand;
                  cache_b_r   <= mul_multiplier;
                  cache_p_r   <= mul_product;
                  state_r     <= SEQ_CORR;
               end else begin
                  state_r <= SEQ_WAIT;
               end
            end
            SEQ_CORR: begin
               if (flush) begin
                  cache_vld_r <= 1'b0;
                  state_r     <= SEQ_IDLE;
               end else begin
                  out_result <= corr_result_s;
                  out_rd     <= rd_r;
                  out_valid  <= 1'b1;
                  state_r    <= SEQ_OUT;
               end
            end
            SEQ_OUT: begin
               if (flush) begin
                  cache_vld_r <= 1'b0;
                  out_valid   <= 1'b0;
                  state_r     <= SEQ_IDLE;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= SEQ_IDLE;
               end else begin
                  state_r <= SEQ_OUT;
               end
            end
            SEQ_DRAIN: begin
               // The multiplier cannot be aborted: wait out its product
               if (flush) begin
                  cache_vld_r <= 1'b0;
               end else begin
                  cache_vld_r <= cache_vld_r;
               end
               if (mul_done) begin
                  state_r <= SEQ_IDLE;
               end else begin
                  state_r <= SEQ_DRAIN;
               end
            end
            default: begin
               state_r   <= SEQ_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural iterative multiplier
// and a scoreboard queue of expected results.
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd;
   logic        flush;
   logic [31:0] mul_multiplicand;
   logic [31:0] mul_multiplier;
   logic        mul_start;
   logic [63:0] mul_product;
   logic        mul_done;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;
   exp_t sb_q[$];

   // Multiplier model state
   int          mdl_lat = 4;
   int          mdl_cnt = 0;
   logic [63:0] mdl_p = 64'd0;
   int          start_cnt = 0;

   mul_sequencer #(.XLEN(32), .TAG_W(5)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_op            (in_op),
      .in_rs1           (in_rs1),
      .in_rs2           (in_rs2),
      .in_rd            (in_rd),
      .flush            (flush),
      .mul_multiplicand (mul_multiplicand),
      .mul_multiplier   (mul_multiplier),
      .mul_start        (mul_start),
      .mul_product      (mul_product),
      .mul_done         (mul_done),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_rd           (out_rd)
   );

   always #5 clk = ~clk;

   // Reference 64-bit products of the three operand signedness flavours
   function automatic logic [63:0] prod_ss(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      return ea * eb;
   endfunction

   function automatic logic [31:0] exp_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] r;
      ea = {{32{a[31]}}, a};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         2'b00:   r = prod_ss(a, b);
         2'b01:   r = prod_ss(a, b) >> 32;
         2'b10:   r = (ea * ub) >> 32;
         default: r = (ua * ub) >> 32;
      endcase
      return r[31:0];
   endfunction

   // Iterative multiplier stand-in: fixed latency, held in reset with the DUT
   always @(posedge clk) begin
      mul_done <= 1'b0;
      if (rst) begin
         mdl_cnt <= 0;
      end else begin
         if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
               mul_done    <= 1'b1;
               mul_product <= mdl_p;
            end
         end
         if (mul_start) begin
            mdl_cnt   <= mdl_lat;
            mdl_p     <= prod_ss(mul_multiplicand, mul_multiplier);
            start_cnt <= start_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait for its result, optionally stall writeback, then compare
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int stall, input int exp_starts, input int exp_lat);
      int   s0;
      int   lat;
      exp_t e;
      s0       = start_cnt;
      in_op    = op;
      in_rs1   = a;
      in_rs2   = b;
      in_rd    = rd;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      sb_q.push_back('{res: exp_res, rd: rd});
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, "_out_valid"}, out_valid, 1'b1);
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "_stall_valid"}, out_valid, 1'b1);
         check({tag, "_stall_result"}, out_result, sb_q[0].res);
         check({tag, "_stall_rd"}, out_rd, sb_q[0].rd);
         check({tag, "_stall_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      e = sb_q.pop_front();
      check({tag, "_result"}, out_result, e.res);
      check({tag, "_rd"}, out_rd, e.rd);
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 1'b0);
      if (exp_starts >= 0) check({tag, "_starts"}, start_cnt - s0, exp_starts);
   endtask

   // Wait (bounded) until the start pulse is visible
   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (!mul_start && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_start_seen"}, mul_start, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_mul_start"}, mul_start, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_result"}, out_result, 32'd0);
      check({tag, "_out_rd"}, out_rd, 5'd0);
      check({tag, "_multiplicand"}, mul_multiplicand, 32'd0);
      check({tag, "_multiplier"}, mul_multiplier, 32'd0);
   endtask

   initial begin
      int          n;
      int          s0;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_rs1    = 32'd0;
      in_rs2    = 32'd0;
      in_rd     = 5'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Basic ops from the four encodings
      do_op("mul_neg", 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, 1, -1);
      do_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, 0, 1, -1);
      do_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, 0, 1, -1);
      // Same operands as the MULHU: served from the cache with correction
      do_op("mulhsu_hit", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'hFFFF_FFFF, 0, 0, 2);

      // MULH then MUL on the same operands: second is a cache hit, stalled 5 cycles
      do_op("mulh_pair", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,
            exp_fn(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 0, 1, -1);
      do_op("mul_pair_hit", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4,
            exp_fn(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 5, 0, 2);

      // Flush in IDLE with an offered op: no accept, cache dropped
      s0       = start_cnt;
      in_op    = 2'b00;
      in_rs1   = 32'h1234_5678;
      in_rs2   = 32'h9ABC_DEF0;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("idle_flush_in_ready", in_ready, 1'b1);
      tick();
      check("idle_flush_no_start", start_cnt - s0, 0);
      check("idle_flush_no_valid", out_valid, 1'b0);
      do_op("after_idle_flush", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6,
            exp_fn(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 0, 1, -1);

      // Flush three cycles into a long multiply
      do_op("fill_x", 2'b00, 32'h11, 32'h22, 5'd7, 32'h242, 0, 1, -1);
      mdl_lat  = 10;
      in_op    = 2'b01;
      in_rs1   = 32'h33;
      in_rs2   = 32'h44;
      in_rd    = 5'd8;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_start("flush_y");
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n = 0;
      while (!mul_done && n < 40) begin
         check("drain_in_ready", in_ready, 1'b0);
         check("drain_no_valid", out_valid, 1'b0);
         tick();
         n++;
      end
      check("drain_done_seen", mul_done, 1'b1);
      tick();
      check("drain_exit_in_ready", in_ready, 1'b1);
      check("drain_exit_no_valid", out_valid, 1'b0);
      mdl_lat = 4;
      do_op("refetch_x_miss", 2'b00, 32'h11, 32'h22, 5'd10, 32'h242, 0, 1, -1);

      // Reset while waiting on the multiplier
      mdl_lat  = 6;
      in_op    = 2'b11;
      in_rs1   = 32'h55;
      in_rs2   = 32'h66;
      in_rd    = 5'd12;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_start("rst_wait");
      tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_wait");
      rst = 1'b0;
      repeat (8) tick();
      check("rst_no_stray_valid", out_valid, 1'b0);
      mdl_lat = 4;
      do_op("after_rst_miss", 2'b00, 32'h11, 32'h22, 5'd13, 32'h242, 0, 1, -1);

      // A few random ops with random writeback stalls
      for (int i = 0; i < 6; i++) begin
         rop     = 2'($urandom_range(0, 3));
         ra      = $urandom();
         rb      = $urandom();
         mdl_lat = $urandom_range(1, 8);
         do_op("rand", rop, ra, rb, 5'($urandom_range(0, 31)), exp_fn(rop, ra, rb),
               $urandom_range(0, 2), 1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
